// File: rtl/issue_scoreboard.sv
// Dual-lane issue scheduler: tracks in-flight writes in EX/MEM/CMT, decides how many
// queue heads issue and selects each source operand from the bypass network or regfile.
module issue_scoreboard #(
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned LOAD_EX_STALL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_stall,
  input  logic [1:0]            iq_size,
  input  logic [3:0]            src_valid,
  input  logic [4*REG_AW-1:0]   src_addr,
  input  logic [1:0]            dst_valid,
  input  logic [2*REG_AW-1:0]   dst_addr,
  input  logic [1:0]            dst_is_load,
  output logic [1:0]            issue_count,
  output logic [11:0]           src_sel,
  output logic [3:0]            rf_read_ena,
  output logic                  busy
);

  localparam logic LoadStall = (LOAD_EX_STALL != 0);

  // Entry index: 0 EX0, 1 EX1, 2 MEM0, 3 MEM1, 4 CMT0, 5 CMT1; bypass select is index + 1.
  logic [5:0]             ent_valid_q;
  logic [5:0]             ent_load_q;
  logic [5:0][REG_AW-1:0] ent_addr_q;

  logic [3:0][2:0] sel_raw;
  logic [3:0]      hazard;
  logic            lane0_issue;
  logic            lane1_issue;
  logic            pair_raw;
  logic [REG_AW-1:0] dst0;
  logic [REG_AW-1:0] dst1;

  assign dst0 = dst_addr[0 +: REG_AW];
  assign dst1 = dst_addr[REG_AW +: REG_AW];

  // Scan from oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [2:0] idx;
    idx     = 3'd0;
    sel_raw = '0;
    hazard  = '0;
    for (int k = 0; k < 4; k++) begin
      if (src_valid[k] && (src_addr[k*REG_AW +: REG_AW] != '0)) begin
        for (int s = 2; s >= 0; s--) begin
          for (int l = 0; l < 2; l++) begin
            idx = 3'(2 * s + l);
            if (ent_valid_q[idx] && (ent_addr_q[idx] == src_addr[k*REG_AW +: REG_AW])) begin
              sel_raw[k] = idx + 3'd1;
              hazard[k]  = (idx[2:1] == 2'b00) && ent_load_q[idx] && LoadStall;
            end
          end
        end
      end
    end
  end

  always_comb begin
    pair_raw = dst_valid[0] && (dst0 != '0) &&
               ((src_valid[2] && (src_addr[2*REG_AW +: REG_AW] == dst0)) ||
                (src_valid[3] && (src_addr[3*REG_AW +: REG_AW] == dst0)));
    lane0_issue = !rst && (iq_size != 2'd0) && !pipe_stall && !hazard[0] && !hazard[1];
    lane1_issue = lane0_issue && iq_size[1] && !hazard[2] && !hazard[3] && !pair_raw;
  end

  always_comb begin
    issue_count = {1'b0, lane0_issue} + {1'b0, lane1_issue};
    busy        = !rst && (ent_valid_q != '0);
    src_sel     = '0;
    rf_read_ena = '0;
    for (int k = 0; k < 4; k++) begin
      if (!rst) begin
        src_sel[k*3 +: 3] = sel_raw[k];
        rf_read_ena[k]    = src_valid[k] && (sel_raw[k] == 3'd0) &&
                            (src_addr[k*REG_AW +: REG_AW] != '0);
      end
    end
  end

  // EX shifts into MEM, MEM into CMT; old CMT retires into the regfile on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid_q <= '0;
      ent_load_q  <= '0;
      ent_addr_q  <= '0;
    end else if (!pipe_stall) begin
      ent_valid_q <= {ent_valid_q[3:0],
                      lane1_issue && dst_valid[1] && (dst1 != '0),
                      lane0_issue && dst_valid[0] && (dst0 != '0)};
      ent_load_q  <= {ent_load_q[3:0], dst_is_load[1], dst_is_load[0]};
      ent_addr_q  <= {ent_addr_q[3:0], dst1, dst0};
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios plus random traffic against a queue-based
// model of in-flight writes aged by pipeline stage.
module tb_issue_scoreboard;

  localparam int unsigned REG_AW = 5;

  logic        clk;
  logic        rst;
  logic        pipe_stall;
  logic [1:0]  iq_size;
  logic [3:0]  src_valid;
  logic [19:0] src_addr;
  logic [1:0]  dst_valid;
  logic [9:0]  dst_addr;
  logic [1:0]  dst_is_load;
  logic [1:0]  issue_count;
  logic [11:0] src_sel;
  logic [3:0]  rf_read_ena;
  logic        busy;

  issue_scoreboard #(.REG_AW(REG_AW), .LOAD_EX_STALL(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_stall  (pipe_stall),
    .iq_size     (iq_size),
    .src_valid   (src_valid),
    .src_addr    (src_addr),
    .dst_valid   (dst_valid),
    .dst_addr    (dst_addr),
    .dst_is_load (dst_is_load),
    .issue_count (issue_count),
    .src_sel     (src_sel),
    .rf_read_ena (rf_read_ena),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one record per in-flight write; age 0 = EX, 1 = MEM, 2 = CMT.
  typedef struct {
    int addr;
    bit ld;
    int lane;
    int age;
  } rec_t;
  rec_t mq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input int a, output bit ld);
    int best_age  = 99;
    int best_lane = -1;
    int ret       = 0;
    ld = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].addr == a &&
          (mq[i].age < best_age || (mq[i].age == best_age && mq[i].lane > best_lane))) begin
        best_age  = mq[i].age;
        best_lane = mq[i].lane;
        ret       = 2 * mq[i].age + mq[i].lane + 1;
        ld        = mq[i].ld;
      end
    end
    return ret;
  endfunction

  // Drive one cycle, compare against the model, then clock and age the model.
  // e_cnt / e_sel0 of -1 skip the extra directed constant checks.
  task automatic step(input bit r, input bit st, input int iqs, input bit [3:0] sv,
                      input int s0, input int s1, input int s2, input int s3,
                      input bit [1:0] dv, input int d0, input int d1, input bit [1:0] ld,
                      input int e_cnt, input int e_sel0);
    int  sa[4];
    int  esel[4];
    bit  ehaz[4];
    bit  mld;
    bit  l0, l1, raw;
    rec_t nq[$];
    rec_t rr;
    sa = '{s0, s1, s2, s3};
    @(negedge clk);
    rst         = r;
    pipe_stall  = st;
    iq_size     = 2'(iqs);
    src_valid   = sv;
    src_addr    = {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
    dst_valid   = dv;
    dst_addr    = {5'(d1), 5'(d0)};
    dst_is_load = ld;
    #1;
    for (int k = 0; k < 4; k++) begin
      esel[k] = 0;
      ehaz[k] = 1'b0;
      if (sv[k] && sa[k] != 0) begin
        esel[k] = lookup(sa[k], mld);
        ehaz[k] = (esel[k] == 1 || esel[k] == 2) && mld;
      end
    end
    raw = dv[0] && d0 != 0 && ((sv[2] && s2 == d0) || (sv[3] && s3 == d0));
    l0  = !r && iqs >= 1 && !st && !ehaz[0] && !ehaz[1];
    l1  = l0 && iqs >= 2 && !ehaz[2] && !ehaz[3] && !raw;
    check("issue_count", int'(issue_count), int'(l0) + int'(l1));
    check("busy", int'(busy), (!r && mq.size() != 0) ? 1 : 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("src_sel%0d", k), int'(src_sel[k*3 +: 3]), r ? 0 : esel[k]);
      check($sformatf("rf_read_ena%0d", k), int'(rf_read_ena[k]),
            (!r && sv[k] && esel[k] == 0 && sa[k] != 0) ? 1 : 0);
    end
    if (e_cnt >= 0) check("plan_count", int'(issue_count), e_cnt);
    if (e_sel0 >= 0) check("plan_sel0", int'(src_sel[2:0]), e_sel0);
    @(posedge clk);
    if (r) begin
      mq.delete();
    end else if (!st) begin
      foreach (mq[i]) begin
        if (mq[i].age < 2) begin
          rr = mq[i];
          rr.age++;
          nq.push_back(rr);
        end
      end
      if (l0 && dv[0] && d0 != 0) nq.push_back('{addr: d0, ld: ld[0], lane: 0, age: 0});
      if (l1 && dv[1] && d1 != 0) nq.push_back('{addr: d1, ld: ld[1], lane: 1, age: 0});
      mq = nq;
    end
  endtask

  initial begin
    rst = 1'b1; pipe_stall = 1'b0; iq_size = '0; src_valid = '0; src_addr = '0;
    dst_valid = '0; dst_addr = '0; dst_is_load = '0;

    // Reset: nothing issues while held, then a full pair issues.
    step(1, 0, 2, 4'b0101, 1, 0, 2, 0, 2'b11, 10, 11, 2'b00, 0, 0);
    step(1, 0, 2, 4'b0101, 1, 0, 2, 0, 2'b11, 10, 11, 2'b00, 0, 0);
    step(0, 0, 2, 4'b0101, 1, 0, 2, 0, 2'b00, 0, 0, 2'b00, 2, 0);

    // r5 walks EX0 -> MEM0 -> CMT0 -> regfile.
    step(0, 0, 1, 4'b0000, 0, 0, 0, 0, 2'b01, 5, 0, 2'b00, 1, -1);
    step(0, 0, 1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 1);
    step(0, 0, 1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 3);
    step(0, 0, 1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 5);
    step(0, 0, 1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 0);

    // Load-use stall on lane1 load r7.
    step(0, 0, 2, 4'b0000, 0, 0, 0, 0, 2'b10, 0, 7, 2'b10, 2, -1);
    step(0, 0, 1, 4'b0001, 7, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2);
    step(0, 0, 1, 4'b0001, 7, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 4);

    // Intra-pair RAW splits the pair.
    step(0, 0, 2, 4'b0100, 0, 0, 3, 0, 2'b01, 3, 0, 2'b00, 1, -1);
    step(0, 0, 1, 4'b0001, 3, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 1);

    // WAW in one pair: youngest lane wins.
    step(0, 0, 2, 4'b0000, 0, 0, 0, 0, 2'b11, 9, 9, 2'b00, 2, -1);
    step(0, 0, 1, 4'b0001, 9, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 2);

    // Stall holds r4 in EX; r0 reads never hit.
    step(0, 0, 1, 4'b0000, 0, 0, 0, 0, 2'b01, 4, 0, 2'b00, 1, -1);
    for (int i = 0; i < 3; i++) step(0, 1, 2, 4'b0011, 4, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1);
    step(0, 0, 1, 4'b0011, 4, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 1);

    // Random traffic over a small register pool to provoke hits.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), $urandom_range(0, 3),
           4'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), 2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
           {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)}, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue-stage scheduler for the dual-lane in-order pipeline.
- Tracks in-flight register writes in EX, MEM and CMT (2 lanes each) and decides how many issue-queue heads (0/1/2) issue this cycle.
- Drives iq_pop_number, and produces per-source bypass selects for the bypass mux and regfile read enables.
- Sits between issue_queue and issue; state advances in lockstep with is_to_ex/ex_to_mem/mem_to_cmt.

Parameters:
REG_AW, 5, register address width (32 architectural registers; address 0 hardwired zero)
LOAD_EX_STALL, 1, 1 = consumer of a load still in EX must stall; 0 = load result forwardable from EX (test only)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
pipe_stall  input  1  downstream hold; pipeline registers do not advance this cycle
iq_size  input  2  valid heads in issue queue; values >=2 treated as 2
src_valid  input  4  source operand used; srcs 0,1 = lane0, srcs 2,3 = lane1
src_addr  input  4*REG_AW  source register addresses, src k at bits [k*REG_AW +: REG_AW]
dst_valid  input  2  lane writes a register
dst_addr  input  2*REG_AW  destination addresses per lane
dst_is_load  input  2  lane instruction is a load
issue_count  output  2  heads issued this cycle (0..2); drives iq_pop_number
src_sel  output  4*3  per-source operand select: 0 regfile, 1 EX0, 2 EX1, 3 MEM0, 4 MEM1, 5 CMT0, 6 CMT1
rf_read_ena  output  4  src_valid[k] and src_sel[k]==0 and addr!=0
busy  output  1  any in-flight entry valid

Behaviour:
- State: 6 entries {valid, addr, is_load}, named EX0/EX1, MEM0/MEM1, CMT0/CMT1. Reset (rst high at clk edge): all valid=0.
- While rst high, outputs are forced: issue_count=0, src_sel=0, rf_read_ena=0, busy=0. After rst deasserts, outputs are combinational from state plus inputs.
- Lookup per source, with addr 0 or src_valid=0 giving sel=0:
  - Match priority, youngest first: EX1 > EX0 > MEM1 > MEM0 > CMT1 > CMT0 > regfile.
  - Only valid entries with equal addr match.
- Hazard per source: matched entry is EX with is_load=1 and LOAD_EX_STALL=1.
- Lane0 issues iff iq_size>=1, pipe_stall=0, and neither lane0 source has a hazard.
- Lane1 issues iff lane0 issues, iq_size>=2, no lane1 source hazard, and no intra-pair RAW.
  - Intra-pair RAW: dst_valid[0], dst_addr[0]!=0, and a valid lane1 source equals dst_addr[0].
  - Never out of order: lane1 never issues alone.
- issue_count = lane0_issue + lane1_issue.
- Advance on each clk edge with pipe_stall=0:
  - CMT<=MEM, MEM<=EX.
  - EXn <= {issue_n && dst_valid[n] && dst_addr[n]!=0, dst_addr[n], dst_is_load[n]}.
  - Prior CMT contents retire; the regfile is written on that same edge.
- With pipe_stall=1: all entries hold, issue_count=0. src_sel is still computed so held operands stay consistent.
- Latency: an instruction issued in cycle t appears in EX at t+1, MEM at t+2, CMT at t+3, and is read from the regfile at t+4.
- WAW in one pair (both lanes same dst): both issue. Later consumers select lane1 (youngest).
- A write to register 0 never allocates an entry; a read of register 0 always gives sel 0 with rf_read_ena=0.
- Reset mid-operation: all in-flight entries drop at the reset edge; no partial shift.

Test Plan:
1. Reset with iq_size=2, independent srcs -> issue_count=0 while rst=1. First cycle after reset -> issue_count=2, all src_sel=0, busy=0.
2. Cycle0: lane0 issues `dst=r5` ALU. Cycle1: lane0 reads r5 -> src_sel[0]=1 (EX0). Repeat one cycle later -> 3 (MEM0), then 5 (CMT0), then 0 with rf_read_ena[0]=1.
3. Load `r7` issues in lane1. Next cycle a lane0 consumer of r7 -> issue_count=0 for one cycle. Following cycle -> issue_count>=1, src_sel[0]=4 (MEM1).
4. Pair {lane0 dst r3; lane1 src r3}, iq_size=2 -> issue_count=1. Next cycle lane1 becomes lane0 -> issue_count>=1, src_sel[0]=1.
5. Pair both dst r9 issued. Next cycle a consumer of r9 -> src_sel=2 (EX1), never 1.
6. EX holds r4 with pipe_stall=1 for 3 cycles -> issue_count=0, entry stays in EX (src_sel=1 for an r4 reader), busy=1. Reads of r0 -> sel 0 and rf_read_ena=0 throughout.
